// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard.
// Two combinational read ports with writeback bypass, one writeback port, and issue gating on busy rd.
module regfile_scoreboard #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NREGS       = 32,
   parameter int unsigned AW          = 5,
   parameter bit          ZERO_REG    = 1'b1,
   parameter bit          RESET_INDEX = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_ready,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [AW:0]     pending_cnt,
   output logic            wb_err
);

   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0]  reg_q [NREGS];
   logic [XLEN-1:0]  reg_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [CW-1:0]    pending_cnt_q;
   logic [CW-1:0]    pending_cnt_d;
   logic             wb_err_q;
   logic             wb_err_d;

   logic             wb_eff;
   logic             issue_acc;

   // Register 0 is hardwired only when ZERO_REG is set.
   function automatic logic is_zero(input logic [AW-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   // Read ports: writeback bypass first, zero register overrides everything.
   always_comb begin
      rs1_data = reg_q[rs1_addr];
      rs2_data = reg_q[rs2_addr];
      if (wb_valid && (wb_rd == rs1_addr)) rs1_data = wb_data;
      if (wb_valid && (wb_rd == rs2_addr)) rs2_data = wb_data;
      if (is_zero(rs1_addr)) rs1_data = '0;
      if (is_zero(rs2_addr)) rs2_data = '0;

      rs1_busy = busy_q[rs1_addr] && !(wb_valid && (wb_rd == rs1_addr)) && !is_zero(rs1_addr);
      rs2_busy = busy_q[rs2_addr] && !(wb_valid && (wb_rd == rs2_addr)) && !is_zero(rs2_addr);
   end

   // A destination freed by this cycle's writeback can be reissued immediately.
   always_comb begin
      issue_ready = !busy_q[issue_rd]
                    || (wb_valid && (wb_rd == issue_rd))
                    || is_zero(issue_rd);
      wb_eff      = wb_valid && !is_zero(wb_rd);
      issue_acc   = issue_valid && issue_ready && !is_zero(issue_rd);
   end

   // Next state: writeback clears busy, a same-register issue re-sets it.
   always_comb begin
      reg_d    = reg_q;
      busy_d   = busy_q;
      wb_err_d = wb_err_q;

      if (wb_eff) begin
         reg_d[wb_rd]  = wb_data;
         busy_d[wb_rd] = 1'b0;
         if (!busy_q[wb_rd]) wb_err_d = 1'b1;
      end
      if (issue_acc) busy_d[issue_rd] = 1'b1;

      pending_cnt_d = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         pending_cnt_d = pending_cnt_d + CW'(busy_d[AW'(i)]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            reg_q[AW'(i)] <= RESET_INDEX ? XLEN'(i) : '0;
         end
         busy_q        <= '0;
         pending_cnt_q <= '0;
         wb_err_q      <= 1'b0;
      end else begin
         reg_q         <= reg_d;
         busy_q        <= busy_d;
         pending_cnt_q <= pending_cnt_d;
         wb_err_q      <= wb_err_d;
      end
   end

   assign pending_cnt = pending_cnt_q;
   assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios with literal expectations plus a
// per-cycle comparison against an architectural model of registers, busy set and error flag.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        rs1_busy, rs2_busy;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [5:0]  pending_cnt;
   logic        wb_err;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_scoreboard #(
      .XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(1'b1), .RESET_INDEX(1'b1)
   ) dut (
      .clk(clk), .reset(reset),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .pending_cnt(pending_cnt), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural model: register values, set of registers with an outstanding producer, error flag.
   logic [31:0] mreg  [32];
   bit          mbusy [32];
   bit          merr;
   bit          mvalid = 1'b0;

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_valid && wb_rd == a) return wb_data;
      return mreg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      return (a != 5'd0) && mbusy[a] && !(wb_valid && wb_rd == a);
   endfunction

   function automatic logic exp_ready();
      return (issue_rd == 5'd0) || !mbusy[issue_rd] || (wb_valid && wb_rd == issue_rd);
   endfunction

   function automatic logic [31:0] exp_pending();
      int n = 0;
      foreach (mbusy[i]) if (mbusy[i]) n++;
      return 32'(n);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            mreg[i]  = 32'(i);
            mbusy[i] = 1'b0;
         end
         merr   = 1'b0;
         mvalid = 1'b1;
      end else if (mvalid) begin
         bit rdy;
         rdy = exp_ready();
         if (wb_valid && wb_rd != 5'd0) begin
            if (!mbusy[wb_rd]) merr = 1'b1;
            mreg[wb_rd]  = wb_data;
            mbusy[wb_rd] = 1'b0;
         end
         if (issue_valid && rdy && issue_rd != 5'd0) mbusy[issue_rd] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("m_rs1_data",   rs1_data,            exp_data(rs1_addr));
         chk("m_rs2_data",   rs2_data,            exp_data(rs2_addr));
         chk("m_rs1_busy",   32'(rs1_busy),       32'(exp_busy(rs1_addr)));
         chk("m_rs2_busy",   32'(rs2_busy),       32'(exp_busy(rs2_addr)));
         chk("m_issue_rdy",  32'(issue_ready),    32'(exp_ready()));
         chk("m_pending",    32'(pending_cnt),    exp_pending());
         chk("m_wb_err",     32'(wb_err),         32'(merr));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; rs1_addr = '0; rs2_addr = '0;
      issue_valid = 1'b0; issue_rd = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // reset contents
      rs1_addr = 5'd7; rs2_addr = 5'd31;
      @(negedge clk); #1;
      chk("t1_rs1", rs1_data, 32'd7);
      chk("t1_rs2", rs2_data, 32'd31);
      chk("t1_busy", 32'({rs1_busy, rs2_busy}), 32'd0);
      chk("t1_pend", 32'(pending_cnt), 32'd0);
      chk("t1_err", 32'(wb_err), 32'd0);

      // bypass then array
      @(posedge clk); #1;
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; rs1_addr = 5'd5;
      @(negedge clk); #1;
      chk("t2_bypass", rs1_data, 32'hDEADBEEF);
      @(posedge clk); #1;
      wb_valid = 1'b0;
      @(negedge clk); #1;
      chk("t2_array", rs1_data, 32'hDEADBEEF);
      chk("t2_err", 32'(wb_err), 32'd1);

      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk); #1;
      chk("rst_x5", rs1_data, 32'd5);
      chk("rst_err", 32'(wb_err), 32'd0);

      // issue then writeback
      @(posedge clk); #1;
      issue_valid = 1'b1; issue_rd = 5'd3;
      @(posedge clk); #1;
      issue_valid = 1'b0; rs1_addr = 5'd3;
      @(negedge clk); #1;
      chk("t3_busy", 32'(rs1_busy), 32'd1);
      chk("t3_pend", 32'(pending_cnt), 32'd1);
      chk("t3_rdy", 32'(issue_ready), 32'd0);
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
      #1;
      chk("t3_wb_busy", 32'(rs1_busy), 32'd0);
      chk("t3_wb_data", rs1_data, 32'h33);
      chk("t3_wb_rdy", 32'(issue_ready), 32'd1);
      @(posedge clk); #1;
      wb_valid = 1'b0;
      @(negedge clk); #1;
      chk("t3_pend0", 32'(pending_cnt), 32'd0);

      // same-cycle writeback and reissue of one register
      @(posedge clk); #1;
      issue_valid = 1'b1; issue_rd = 5'd4; rs1_addr = 5'd4;
      @(posedge clk); #1;
      issue_valid = 1'b0;
      @(negedge clk); #1;
      chk("t4_pend1", 32'(pending_cnt), 32'd1);
      @(posedge clk); #1;
      wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44; issue_valid = 1'b1;
      @(negedge clk); #1;
      chk("t4_rdy", 32'(issue_ready), 32'd1);
      @(posedge clk); #1;
      wb_valid = 1'b0; issue_valid = 1'b0;
      @(negedge clk); #1;
      chk("t4_pend", 32'(pending_cnt), 32'd1);
      chk("t4_busy", 32'(rs1_busy), 32'd1);
      chk("t4_data", rs1_data, 32'h44);
      @(posedge clk); #1;
      wb_valid = 1'b1; wb_data = 32'h45;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      @(negedge clk); #1;
      chk("t4_clear", 32'(pending_cnt), 32'd0);

      // zero register
      @(posedge clk); #1;
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h55; rs1_addr = 5'd0;
      @(negedge clk); #1;
      chk("t5_x0_byp", rs1_data, 32'd0);
      @(posedge clk); #1;
      wb_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd0;
      @(negedge clk); #1;
      chk("t5_x0", rs1_data, 32'd0);
      chk("t5_rdy", 32'(issue_ready), 32'd1);
      @(posedge clk); #1;
      issue_valid = 1'b0;
      @(negedge clk); #1;
      chk("t5_pend", 32'(pending_cnt), 32'd0);
      chk("t5_err", 32'(wb_err), 32'd0);

      // stray writeback, then reset over pending producers
      @(posedge clk); #1;
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99; rs1_addr = 5'd9;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      @(negedge clk); #1;
      chk("t6_err", 32'(wb_err), 32'd1);
      chk("t6_x9", rs1_data, 32'h99);
      @(posedge clk); #1;
      issue_valid = 1'b1; issue_rd = 5'd10;
      @(posedge clk); #1;
      issue_rd = 5'd11;
      @(posedge clk); #1;
      issue_valid = 1'b0;
      @(negedge clk); #1;
      chk("t6_pend2", 32'(pending_cnt), 32'd2);
      @(posedge clk); #1;
      reset = 1'b1; issue_valid = 1'b1; issue_rd = 5'd12;
      wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hAA;
      @(posedge clk); #1;
      reset = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0; rs2_addr = 5'd10;
      @(negedge clk); #1;
      chk("t6_rst_pend", 32'(pending_cnt), 32'd0);
      chk("t6_rst_err", 32'(wb_err), 32'd0);
      chk("t6_rst_x9", rs1_data, 32'd9);
      chk("t6_rst_x10", rs2_data, 32'd10);
      chk("t6_rst_busy", 32'(rs2_busy), 32'd0);

      // mixed traffic checked by the model
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         rs1_addr    = 5'($urandom_range(0, 31));
         rs2_addr    = 5'($urandom_range(0, 31));
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd    = 5'($urandom_range(0, 7));
         wb_valid    = 1'($urandom_range(0, 1));
         wb_rd       = 5'($urandom_range(0, 7));
         wb_data     = $urandom;
         reset       = ($urandom_range(0, 63) == 0);
      end
      @(posedge clk); #1;
      issue_valid = 1'b0; wb_valid = 1'b0; reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
